lcg_accum: RTL and testbench

- Parametrised linear congruential generator with a sample accumulator.
- Produces `number` pseudo-random values x[k+1] = (A*x[k] + B) mod 2^WIDTH using a sequential shift-add multiplier. Sums them into a configurable-width accumulator with wrap or saturate mode, then reports completion with a start/busy/done handshake.
- Sits in the sub-section datapath as the stimulus/checksum source for downstream blocks.

---
 rtl/lcg_accum_if.sv | 31 +++
 rtl/lcg_accum.sv | 115 +++++++++++
 tb/tb_lcg_accum.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/lcg_accum_if.sv
// lcg_accum_if: start/busy/done handshake and data bus for the LCG sample accumulator.
//   master (requester): drives start, number, sat_mode, seed_load, seed_in;
//                       observes busy, rnd, rnd_valid, sum, overflow, done.
//   slave  (lcg_accum): the mirror image of master.
interface lcg_accum_if #(
    parameter int WIDTH     = 16,
    parameter int SUM_WIDTH = 16,
    parameter int CNT_WIDTH = 12
);
    logic                 start;
    logic [CNT_WIDTH-1:0] number;
    logic                 sat_mode;
    logic                 seed_load;
    logic [WIDTH-1:0]     seed_in;
    logic                 busy;
    logic [WIDTH-1:0]     rnd;
    logic                 rnd_valid;
    logic [SUM_WIDTH-1:0] sum;
    logic                 overflow;
    logic                 done;

    modport master (
        output start, number, sat_mode, seed_load, seed_in,
        input  busy, rnd, rnd_valid, sum, overflow, done
    );

    modport slave (
        input  start, number, sat_mode, seed_load, seed_in,
        output busy, rnd, rnd_valid, sum, overflow, done
    );
endinterface

// File: rtl/lcg_accum.sv
// lcg_accum: LCG x' = (A*x + B) mod 2^WIDTH with shift-add multiply and wrap/saturate sample accumulator.
//   CLK   : clock, all state changes on the rising edge
//   RST_n : asynchronous active-low reset
//   bus   : lcg_accum_if.slave (start/number/sat_mode/seed_load/seed_in in;
//           busy/rnd/rnd_valid/sum/overflow/done out)
module lcg_accum #(
    parameter int WIDTH     = 16,
    parameter int SUM_WIDTH = 16,
    parameter int CNT_WIDTH = 12,
    parameter int A         = 3,
    parameter int A_BITS    = 2,
    parameter int B         = 3,
    parameter int SEED      = 2633
) (
    input logic        CLK,
    input logic        RST_n,
    lcg_accum_if.slave bus
);
    localparam int JW = (A_BITS > 1) ? $clog2(A_BITS) : 1;
    localparam logic [A_BITS-1:0] A_V = A_BITS'(A);

    typedef enum logic [1:0] {IDLE, MUL, STEP, DONE} state_t;

    state_t               state, nxt;
    logic [WIDTH-1:0]     x_state, acc, x_next;
    logic [JW-1:0]        j;
    logic [CNT_WIDTH-1:0] count, num_r;
    logic                 sat_r;
    logic [WIDTH-1:0]     rnd;
    logic                 rnd_valid;
    logic [SUM_WIDTH-1:0] sum, sum_next;
    logic [SUM_WIDTH:0]   wide;
    logic                 overflow;
    logic                 last_bit, last_sample;

    assign x_next      = acc + WIDTH'(B);
    assign wide        = {1'b0, sum} + (SUM_WIDTH+1)'(x_next);
    // A saturated sum stays at max: any nonzero addend carries again, zero leaves it alone.
    assign sum_next    = (wide[SUM_WIDTH] && sat_r) ? '1 : wide[SUM_WIDTH-1:0];
    assign last_bit    = (j == JW'(A_BITS - 1));
    assign last_sample = (count + 1'b1 == num_r);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: nxt = bus.start ? ((bus.number == '0) ? DONE : MUL) : IDLE;
            MUL:  nxt = last_bit ? STEP : MUL;
            STEP: nxt = last_sample ? DONE : MUL;
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            x_state   <= WIDTH'(SEED);
            acc       <= '0;
            j         <= '0;
            count     <= '0;
            num_r     <= '0;
            sat_r     <= 1'b0;
            rnd       <= '0;
            rnd_valid <= 1'b0;
            sum       <= '0;
            overflow  <= 1'b0;
        end else begin
            rnd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // The seed lands before the first MUL cycle, so a same-cycle start uses it.
                    if (bus.seed_load)
                        x_state <= bus.seed_in;
                    if (bus.start) begin
                        sum      <= '0;
                        overflow <= 1'b0;
                        count    <= '0;
                        acc      <= '0;
                        j        <= '0;
                        num_r    <= bus.number;
                        sat_r    <= bus.sat_mode;
                    end
                end
                MUL: begin
                    acc <= acc + (A_V[j] ? (x_state << j) : '0);
                    j   <= j + 1'b1;
                end
                STEP: begin
                    x_state   <= x_next;
                    rnd       <= x_next;
                    rnd_valid <= 1'b1;
                    sum       <= sum_next;
                    overflow  <= overflow | wide[SUM_WIDTH];
                    count     <= count + 1'b1;
                    acc       <= '0;
                    j         <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state == MUL) || (state == STEP);
    assign bus.done      = (state == DONE);
    assign bus.rnd       = rnd;
    assign bus.rnd_valid = rnd_valid;
    assign bus.sum       = sum;
    assign bus.overflow  = overflow;
endmodule

// File: tb/tb_lcg_accum.sv
// tb_lcg_accum: scoreboard bench for lcg_accum using hand-computed LCG sequences.
module tb_lcg_accum;
    localparam int LAT = 3;

    typedef struct {
        int kind;
        int val;
        int ovf;
        int cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb[$];

    lcg_accum_if bus ();

    lcg_accum dut (
        .CLK  (clk),
        .RST_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic mon(input int kind, input int val, input int ovf);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: got val %0d at edge %0d, none expected", kind ? "done" : "rnd", val, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.val != val || e.ovf != ovf || e.cyc != cyc) begin
                errors++;
                $display("FAIL sb_%s: got kind %0d val %0d ovf %0d edge %0d expected kind %0d val %0d ovf %0d edge %0d",
                         kind ? "done" : "rnd", kind, val, ovf, cyc, e.kind, e.val, e.ovf, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rnd_valid)
                mon(0, int'(bus.rnd), 0);
            if (bus.done)
                mon(1, int'(bus.sum), int'(bus.overflow));
        end
    end

    task automatic push_rnd(input int e0, input int k, input int v);
        sb.push_back('{0, v, 0, e0 + LAT * k});
    endtask

    task automatic push_done(input int e0, input int n, input int s, input int o);
        sb.push_back('{1, s, o, e0 + LAT * n});
    endtask

    task automatic go(input int n, input bit sat, input bit ld, input int sd, output int e0);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.number    = 12'(n);
        bus.sat_mode  = sat;
        bus.seed_load = ld;
        bus.seed_in   = 16'(sd);
        e0 = cyc + 1;
    endtask

    task automatic idle_in();
        @(negedge clk);
        bus.start     = 1'b0;
        bus.seed_load = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c)
            @(negedge clk);
    endtask

    task automatic drain(input string nm, input int s, input int o);
        int t = 0;
        while ((sb.size() != 0 || bus.busy) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d pending expected 0", nm, sb.size());
        end
        @(negedge clk);
        chk({nm, "_sum_hold"}, int'(bus.sum), s);
        chk({nm, "_ovf_hold"}, int'(bus.overflow), o);
    endtask

    initial begin
        int e0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.number    = '0;
        bus.sat_mode  = 1'b0;
        bus.seed_load = 1'b0;
        bus.seed_in   = '0;
        checks        = 0;
        errors        = 0;
        repeat (2) @(negedge clk);
        chk("rst_rnd", int'(bus.rnd), 0);
        chk("rst_sum", int'(bus.sum), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_ovf", int'(bus.overflow), 0);
        chk("rst_valid", int'(bus.rnd_valid), 0);
        rst_n = 1'b1;

        go(3, 0, 0, 0, e0);
        push_rnd(e0, 1, 7902);
        push_rnd(e0, 2, 23709);
        push_rnd(e0, 3, 5594);
        push_done(e0, 3, 37205, 0);
        idle_in();
        chk("run3_busy", int'(bus.busy), 1);
        drain("run3", 37205, 0);
        chk("run3_idle_busy", int'(bus.busy), 0);

        go(1, 0, 0, 0, e0);
        push_rnd(e0, 1, 16785);
        push_done(e0, 1, 16785, 0);
        idle_in();
        drain("cont", 16785, 0);

        go(0, 0, 1, 2633, e0);
        bus.start = 1'b0;
        idle_in();
        go(1, 0, 0, 0, e0);
        push_rnd(e0, 1, 7902);
        push_done(e0, 1, 7902, 0);
        idle_in();
        drain("reseed", 7902, 0);

        go(0, 0, 0, 0, e0);
        push_done(e0, 0, 0, 0);
        idle_in();
        drain("zero", 0, 0);

        go(5, 0, 1, 2633, e0);
        push_rnd(e0, 1, 7902);
        push_rnd(e0, 2, 23709);
        push_rnd(e0, 3, 5594);
        push_rnd(e0, 4, 16785);
        push_rnd(e0, 5, 50358);
        push_done(e0, 5, 38812, 1);
        idle_in();
        drain("wrap5", 38812, 1);

        go(5, 1, 1, 2633, e0);
        push_rnd(e0, 1, 7902);
        push_rnd(e0, 2, 23709);
        push_rnd(e0, 3, 5594);
        push_rnd(e0, 4, 16785);
        push_rnd(e0, 5, 50358);
        push_done(e0, 5, 65535, 1);
        idle_in();
        drain("sat5", 65535, 1);

        go(3, 0, 1, 2633, e0);
        push_rnd(e0, 1, 7902);
        push_rnd(e0, 2, 23709);
        push_rnd(e0, 3, 5594);
        push_done(e0, 3, 37205, 0);
        idle_in();
        wait_cyc(e0 + 2);
        bus.start     = 1'b1;
        bus.number    = 12'd7;
        bus.sat_mode  = 1'b1;
        bus.seed_load = 1'b1;
        bus.seed_in   = 16'd1234;
        idle_in();
        wait_cyc(e0 + 9);
        chk("done_cycle_done", int'(bus.done), 1);
        bus.start = 1'b1;
        idle_in();
        chk("start_at_done_busy", int'(bus.busy), 0);
        drain("ignored", 37205, 0);

        go(3, 0, 1, 2633, e0);
        push_rnd(e0, 1, 7902);
        idle_in();
        wait_cyc(e0 + 4);
        chk("pre_abort_busy", int'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_rnd", int'(bus.rnd), 0);
        chk("abort_sum", int'(bus.sum), 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_pending", sb.size(), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        go(1, 0, 0, 0, e0);
        push_rnd(e0, 1, 7902);
        push_done(e0, 1, 7902, 0);
        idle_in();
        drain("after_abort", 7902, 0);

        repeat (4) @(negedge clk);
        chk("final_pending", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
